pc_npc_sequencer: RTL and testbench

- Drives the SPARC PC/nPC pair and produces the next-address value that feeds the nPC register.
- Each time the control unit advances, it applies delayed-branch semantics: sequential, taken Bicc, annulled delay slot, register-indirect jump (JMPL/RETT) and trap entry.
- It sits between the control unit, the branch-condition logic and the nPC register in the data path.

---
 rtl/pc_npc_sequencer_pkg.sv | 29 ++
 rtl/pc_npc_sequencer_next_mux.sv | 60 ++++++
 rtl/pc_npc_sequencer.sv | 91 +++++++++
 tb/tb_pc_npc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_npc_sequencer_pkg.sv
// Shared types and constants for the SPARC PC/nPC sequencer.
// Holds the FSM encoding, the instruction size and the next-address source priority.
package pc_npc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RST,
    ST_BOOT,
    ST_RUN
  } seq_state_t;

  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    SEL_TRAP,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } next_sel_t;

  // Trap beats jump, jump beats a taken branch, otherwise fall through.
  function automatic next_sel_t pick_sel(input logic trap, input logic jump,
                                         input logic branch_taken);
    if (trap)              return SEL_TRAP;
    else if (jump)         return SEL_JUMP;
    else if (branch_taken) return SEL_BRANCH;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_npc_sequencer_next_mux.sv
// Combinational next-PC/nPC selector with delayed-branch and annul handling.
// Loaded addresses are word-aligned and a flag reports dropped low bits.
module pc_next_mux
  import pc_npc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] cur_npc,
  input  logic              slot_annulled,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              branch_always,
  input  logic              annul_bit,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vector,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] next_npc,
  output logic              next_annul,
  output logic              misaligned
);

  logic              eff_branch;
  logic              eff_jump;
  next_sel_t         sel;
  logic [ADDR_W-1:0] target_al;
  logic [ADDR_W-1:0] trap_al;
  logic [ADDR_W-1:0] seq_npc;

  // A squashed delay slot may not redirect control flow; only a trap can.
  assign eff_branch = branch & ~slot_annulled;
  assign eff_jump   = jump & ~slot_annulled;
  assign sel        = pick_sel(trap, eff_jump, eff_branch & branch_taken);

  assign target_al = {target[ADDR_W-1:2], 2'b00};
  assign trap_al   = {trap_vector[ADDR_W-1:2], 2'b00};
  assign seq_npc   = cur_npc + ADDR_W'(INSTR_BYTES);

  always_comb begin
    next_pc    = cur_npc;
    next_npc   = seq_npc;
    misaligned = 1'b0;
    next_annul = eff_branch & annul_bit & (~branch_taken | branch_always)
                 & ~trap & ~eff_jump;
    unique case (sel)
      SEL_TRAP: begin
        next_pc    = trap_al;
        next_npc   = trap_al + ADDR_W'(INSTR_BYTES);
        misaligned = |trap_vector[1:0];
      end
      SEL_JUMP, SEL_BRANCH: begin
        next_npc   = target_al;
        misaligned = |target[1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_npc_sequencer.sv
// SPARC PC/nPC sequencer: boot FSM plus PC/nPC registers updated on the falling edge.
// Produces the nPC register load value and enable each time the control unit steps.
module pc_npc_sequencer
  import pc_npc_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              branch,
  input  logic              branch_taken,
  input  logic              branch_always,
  input  logic              annul_bit,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              trap,
  input  logic [ADDR_W-1:0] trap_vector,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc_out,
  output logic              npc_load,
  output logic              slot_annulled,
  output logic              misaligned,
  output logic              valid
);

  localparam logic [ADDR_W-1:0] RESET_NPC = RESET_VECTOR + ADDR_W'(INSTR_BYTES);

  seq_state_t        state;
  seq_state_t        state_next;
  logic              step;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] next_npc;
  logic              next_annul;
  logic              next_mis;

  assign step  = (state == ST_RUN) & (advance | trap);
  assign valid = (state == ST_RUN);

  pc_next_mux #(.ADDR_W(ADDR_W)) u_next_mux (
    .cur_npc       (npc_out),
    .slot_annulled (slot_annulled),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_always (branch_always),
    .annul_bit     (annul_bit),
    .jump          (jump),
    .target        (target),
    .trap          (trap),
    .trap_vector   (trap_vector),
    .next_pc       (next_pc),
    .next_npc      (next_npc),
    .next_annul    (next_annul),
    .misaligned    (next_mis)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RST:  state_next = ST_BOOT;
      ST_BOOT: state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // The data path samples on the falling edge, so all state moves there too.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RST;
      pc            <= RESET_VECTOR;
      npc_out       <= RESET_NPC;
      npc_load      <= 1'b0;
      slot_annulled <= 1'b0;
      misaligned    <= 1'b0;
    end else begin
      state <= state_next;
      if (step) begin
        pc            <= next_pc;
        npc_out       <= next_npc;
        npc_load      <= 1'b1;
        slot_annulled <= next_annul;
        misaligned    <= next_mis;
      end else begin
        npc_load   <= 1'b0;
        misaligned <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Directed self-checking bench for pc_npc_sequencer.
// Vectors walk boot, sequential flow, branches, annulled slots, trap, wrap and async reset.
module tb_pc_npc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        advance;
  logic        branch;
  logic        branch_taken;
  logic        branch_always;
  logic        annul_bit;
  logic        jump;
  logic [31:0] target;
  logic        trap;
  logic [31:0] trap_vector;
  logic [31:0] pc;
  logic [31:0] npc_out;
  logic        npc_load;
  logic        slot_annulled;
  logic        misaligned;
  logic        valid;

  int numCompared   = 0;
  int numMismatched = 0;

  pc_npc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (advance),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .branch_always (branch_always),
    .annul_bit     (annul_bit),
    .jump          (jump),
    .target        (target),
    .trap          (trap),
    .trap_vector   (trap_vector),
    .pc            (pc),
    .npc_out       (npc_out),
    .npc_load      (npc_load),
    .slot_annulled (slot_annulled),
    .misaligned    (misaligned),
    .valid         (valid)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    advance       = 1'b0;
    branch        = 1'b0;
    branch_taken  = 1'b0;
    branch_always = 1'b0;
    annul_bit     = 1'b0;
    jump          = 1'b0;
    target        = 32'h0;
    trap          = 1'b0;
    trap_vector   = 32'h0;
  endtask

  // Drive one vector across a falling edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic adv, input logic br, input logic tk,
                               input logic ba, input logic an, input logic jmp,
                               input logic [31:0] tgt, input logic tr,
                               input logic [31:0] tv);
    advance       = adv;
    branch        = br;
    branch_taken  = tk;
    branch_always = ba;
    annul_bit     = an;
    jump          = jmp;
    target        = tgt;
    trap          = tr;
    trap_vector   = tv;
    @(negedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkState(input string tag, input logic [31:0] expPc,
                            input logic [31:0] expNpc, input logic expLoad,
                            input logic expAnnul, input logic expMis,
                            input logic expValid);
    checkOutput({tag, ".pc"},    pc,                   expPc);
    checkOutput({tag, ".npc"},   npc_out,              expNpc);
    checkOutput({tag, ".load"},  {31'b0, npc_load},      {31'b0, expLoad});
    checkOutput({tag, ".annul"}, {31'b0, slot_annulled}, {31'b0, expAnnul});
    checkOutput({tag, ".mis"},   {31'b0, misaligned},    {31'b0, expMis});
    checkOutput({tag, ".valid"}, {31'b0, valid},         {31'b0, expValid});
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkState("reset", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("boot", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("run", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("seq1", 32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("seq2", 32'h8, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("seq3", 32'hC, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);

    // Branch without Advance is not a step.
    applyStimulus(0, 1, 1, 0, 0, 0, 32'h500, 0, 32'h0);
    checkState("idle", 32'hC, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 1, 1, 0, 0, 0, 32'h100, 0, 32'h0);
    checkState("bicc", 32'h10, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("bicc_tgt", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 1, 1, 1, 1, 0, 32'h200, 0, 32'h0);
    checkState("ba_a", 32'h104, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 1, 1, 0, 0, 0, 32'h300, 0, 32'h0);
    checkState("squashed", 32'h200, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 1, 0, 0, 1, 0, 32'h700, 0, 32'h0);
    checkState("bn_a", 32'h204, 32'h208, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("hold_annul", 32'h204, 32'h208, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("after_bn_a", 32'h208, 32'h20C, 1'b1, 1'b0, 1'b0, 1'b1);

    applyStimulus(0, 0, 0, 0, 0, 1, 32'h900, 1, 32'h802);
    checkState("trap", 32'h800, 32'h804, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("trap_idle", 32'h800, 32'h804, 1'b0, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 0, 0, 0, 0, 1, 32'h403, 0, 32'h0);
    checkState("jmpl_mis", 32'h804, 32'h400, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    checkState("jmpl_hi", 32'h400, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("wrap1", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("wrap2", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checkState("wrap3", 32'h0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_rst", 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
